// File: rtl/gcn_pkg.sv
// Shared types and width helpers for the two-layer graph-convolution engine.
// All datapath widths are derived here so the engine and its PEs agree on them.
package gcn_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        L1   = 3'd1,
        AGG  = 3'd2,
        L2   = 3'd3,
        DONE = 3'd4
    } gcn_state_t;

    function automatic int ax_w(input int n_nodes, input int x_w);
        return x_w + $clog2(n_nodes);
    endfunction

    function automatic int h_w(input int ax_width, input int w_w, input int in_feat);
        return ax_width + w_w + $clog2(in_feat);
    endfunction

    function automatic int ah_w(input int h_width, input int n_nodes);
        return h_width + $clog2(n_nodes);
    endfunction

    function automatic int out_w(input int ah_width, input int w_w, input int hid_feat);
        return ah_width + w_w + $clog2(hid_feat);
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // A counter always needs at least one bit, even for a single-step layer.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/gcn_node_pe.sv
// Per-node processing element: signed dot product of a K-lane operand vector
// with one weight column, followed by an optional ReLU.
module gcn_node_pe #(
    parameter int K   = 4,
    parameter int A_W = 16,
    parameter int W_W = 5,
    parameter int P_W = 23
) (
    input  logic [K*A_W-1:0] vec_i,
    input  logic [K*W_W-1:0] wcol_i,
    input  logic             relu_i,
    output logic [P_W-1:0]   sum_o
);

    logic signed [P_W-1:0] acc;
    logic signed [P_W-1:0] a_ext;
    logic signed [P_W-1:0] w_ext;

    // Both operands are sign-extended to the full result width before the
    // multiply, so the product and every partial sum are exact.
    always_comb begin
        acc   = '0;
        a_ext = '0;
        w_ext = '0;
        for (int k = 0; k < K; k++) begin
            a_ext = {{(P_W-A_W){vec_i[k*A_W+A_W-1]}}, vec_i[k*A_W +: A_W]};
            w_ext = {{(P_W-W_W){wcol_i[k*W_W+W_W-1]}}, wcol_i[k*W_W +: W_W]};
            acc   = acc + a_ext * w_ext;
        end
        sum_o = (relu_i && acc[P_W-1]) ? '0 : acc;
    end

endmodule

// File: rtl/gcn_engine.sv
// Two-layer graph-convolution core: captures one inference, then evaluates
// layer 1 and layer 2 one neuron per cycle with all nodes in parallel.
module gcn_engine
    import gcn_pkg::*;
#(
    parameter int NUM_NODES  = 4,
    parameter int IN_FEAT    = 4,
    parameter int HID_FEAT   = 4,
    parameter int OUT_FEAT   = 2,
    parameter int X_W        = 5,
    parameter int W_W        = 5,
    localparam int AX_W      = ax_w(NUM_NODES, X_W),
    localparam int H_W       = h_w(AX_W, W_W, IN_FEAT),
    localparam int AH_W      = ah_w(H_W, NUM_NODES),
    localparam int OUT_W     = out_w(AH_W, W_W, HID_FEAT)
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [NUM_NODES*NUM_NODES-1:0]        adj,
    input  logic [NUM_NODES*IN_FEAT*X_W-1:0]      x_in,
    input  logic [IN_FEAT*HID_FEAT*W_W-1:0]       w1,
    input  logic [HID_FEAT*OUT_FEAT*W_W-1:0]      w2,
    input  logic                                  out_relu,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [NUM_NODES*OUT_FEAT*OUT_W-1:0]   out_data,
    output logic [2:0]                            dbg_state_o
);

    localparam int N     = NUM_NODES;
    localparam int OP_W  = AH_W;
    localparam int K_PE  = max_int(IN_FEAT, HID_FEAT);
    localparam int PE_W  = OP_W + W_W + $clog2(K_PE);
    localparam int CNT_W = cnt_w(max_int(HID_FEAT, OUT_FEAT));

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; valid is held by its source until that edge, ready never
    // depends combinationally on valid.

    gcn_state_t state_q, state_d;
    logic [CNT_W-1:0]               cnt_q, cnt_d;
    logic [N*N-1:0]                 adj_q, adj_d;
    logic [N*IN_FEAT*X_W-1:0]       x_q, x_d;
    logic [IN_FEAT*HID_FEAT*W_W-1:0] w1_q, w1_d;
    logic [HID_FEAT*OUT_FEAT*W_W-1:0] w2_q, w2_d;
    logic                           relu_q, relu_d;
    logic [N*HID_FEAT*H_W-1:0]      hid_q, hid_d;
    logic [N*HID_FEAT*AH_W-1:0]     ah_q, ah_d;
    logic [N*OUT_FEAT*OUT_W-1:0]    out_q, out_d;

    logic [N*IN_FEAT*AX_W-1:0]      ax;
    logic [AX_W-1:0]                ax_acc;
    logic [N*HID_FEAT*AH_W-1:0]     ah_sum;
    logic [AH_W-1:0]                ah_acc;
    logic [N*K_PE*OP_W-1:0]         pe_vec;
    logic [K_PE*W_W-1:0]            pe_w;
    logic                           pe_relu;
    logic [N*PE_W-1:0]              pe_sum;

    // First-layer neighbour aggregation straight from the captured features.
    always_comb begin
        ax     = '0;
        ax_acc = '0;
        for (int i = 0; i < N; i++) begin
            for (int f = 0; f < IN_FEAT; f++) begin
                ax_acc = '0;
                for (int j = 0; j < N; j++) begin
                    if (adj_q[i*N+j]) begin
                        ax_acc = ax_acc + {{(AX_W-X_W){x_q[(j*IN_FEAT+f)*X_W+X_W-1]}},
                                           x_q[(j*IN_FEAT+f)*X_W +: X_W]};
                    end
                end
                ax[(i*IN_FEAT+f)*AX_W +: AX_W] = ax_acc;
            end
        end
    end

    // Second-layer neighbour aggregation over the hidden activations.
    always_comb begin
        ah_sum = '0;
        ah_acc = '0;
        for (int i = 0; i < N; i++) begin
            for (int h = 0; h < HID_FEAT; h++) begin
                ah_acc = '0;
                for (int j = 0; j < N; j++) begin
                    if (adj_q[i*N+j]) begin
                        ah_acc = ah_acc + {{(AH_W-H_W){hid_q[(j*HID_FEAT+h)*H_W+H_W-1]}},
                                           hid_q[(j*HID_FEAT+h)*H_W +: H_W]};
                    end
                end
                ah_sum[(i*HID_FEAT+h)*AH_W +: AH_W] = ah_acc;
            end
        end
    end

    // The PEs serve both layers; unused lanes are zeroed so they add nothing.
    always_comb begin
        pe_vec  = '0;
        pe_w    = '0;
        pe_relu = 1'b1;
        if (state_q == L2) begin
            pe_relu = relu_q;
            for (int n = 0; n < N; n++) begin
                for (int k = 0; k < HID_FEAT; k++) begin
                    pe_vec[(n*K_PE+k)*OP_W +: OP_W] = ah_q[(n*HID_FEAT+k)*AH_W +: AH_W];
                end
            end
            for (int o = 0; o < OUT_FEAT; o++) begin
                if (cnt_q == CNT_W'(o)) begin
                    for (int k = 0; k < HID_FEAT; k++) begin
                        pe_w[k*W_W +: W_W] = w2_q[(o*HID_FEAT+k)*W_W +: W_W];
                    end
                end
            end
        end else begin
            for (int n = 0; n < N; n++) begin
                for (int k = 0; k < IN_FEAT; k++) begin
                    pe_vec[(n*K_PE+k)*OP_W +: OP_W] =
                        {{(OP_W-AX_W){ax[(n*IN_FEAT+k)*AX_W+AX_W-1]}},
                         ax[(n*IN_FEAT+k)*AX_W +: AX_W]};
                end
            end
            for (int h = 0; h < HID_FEAT; h++) begin
                if (cnt_q == CNT_W'(h)) begin
                    for (int k = 0; k < IN_FEAT; k++) begin
                        pe_w[k*W_W +: W_W] = w1_q[(h*IN_FEAT+k)*W_W +: W_W];
                    end
                end
            end
        end
    end

    for (genvar n = 0; n < N; n++) begin : g_pe
        gcn_node_pe #(
            .K   (K_PE),
            .A_W (OP_W),
            .W_W (W_W),
            .P_W (PE_W)
        ) u_pe (
            .vec_i  (pe_vec[n*K_PE*OP_W +: K_PE*OP_W]),
            .wcol_i (pe_w),
            .relu_i (pe_relu),
            .sum_o  (pe_sum[n*PE_W +: PE_W])
        );
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        adj_d   = adj_q;
        x_d     = x_q;
        w1_d    = w1_q;
        w2_d    = w2_q;
        relu_d  = relu_q;
        hid_d   = hid_q;
        ah_d    = ah_q;
        out_d   = out_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    adj_d   = adj;
                    x_d     = x_in;
                    w1_d    = w1;
                    w2_d    = w2;
                    relu_d  = out_relu;
                    cnt_d   = '0;
                    state_d = L1;
                end
            end
            L1: begin
                for (int n = 0; n < N; n++) begin
                    for (int h = 0; h < HID_FEAT; h++) begin
                        if (cnt_q == CNT_W'(h)) begin
                            hid_d[(n*HID_FEAT+h)*H_W +: H_W] = pe_sum[n*PE_W +: H_W];
                        end
                    end
                end
                if (cnt_q == CNT_W'(HID_FEAT-1)) begin
                    cnt_d   = '0;
                    state_d = AGG;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            AGG: begin
                ah_d    = ah_sum;
                cnt_d   = '0;
                state_d = L2;
            end
            L2: begin
                for (int n = 0; n < N; n++) begin
                    for (int o = 0; o < OUT_FEAT; o++) begin
                        if (cnt_q == CNT_W'(o)) begin
                            out_d[(n*OUT_FEAT+o)*OUT_W +: OUT_W] = pe_sum[n*PE_W +: OUT_W];
                        end
                    end
                end
                if (cnt_q == CNT_W'(OUT_FEAT-1)) begin
                    cnt_d   = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            adj_q   <= '0;
            x_q     <= '0;
            w1_q    <= '0;
            w2_q    <= '0;
            relu_q  <= 1'b0;
            hid_q   <= '0;
            ah_q    <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            adj_q   <= adj_d;
            x_q     <= x_d;
            w1_q    <= w1_d;
            w2_q    <= w2_d;
            relu_q  <= relu_d;
            hid_q   <= hid_d;
            ah_q    <= ah_d;
            out_q   <= out_d;
        end
    end

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = (state_q == DONE);
    assign out_data    = out_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_gcn_engine.sv
// Self-checking bench for gcn_engine: per-scenario tasks, a result queue filled
// at capture time and drained when out_valid is seen.
module tb_gcn_engine;

    localparam int N  = 4;
    localparam int IF = 4;
    localparam int HF = 4;
    localparam int OF = 2;
    localparam int XW = 5;
    localparam int WW = 5;
    localparam int OW = 23;
    localparam int OB = N*OF*OW;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 in_valid;
    logic                 in_ready;
    logic [N*N-1:0]       adj;
    logic [N*IF*XW-1:0]   x_in;
    logic [IF*HF*WW-1:0]  w1;
    logic [HF*OF*WW-1:0]  w2;
    logic                 out_relu;
    logic                 out_valid;
    logic                 out_ready;
    logic [OB-1:0]        out_data;
    logic [2:0]           dbg_state;

    logic [OB-1:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;

    gcn_engine #(
        .NUM_NODES (N),
        .IN_FEAT   (IF),
        .HID_FEAT  (HF),
        .OUT_FEAT  (OF),
        .X_W       (XW),
        .W_W       (WW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .adj         (adj),
        .x_in        (x_in),
        .w1          (w1),
        .w2          (w2),
        .out_relu    (out_relu),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .dbg_state_o (dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [N*IF*XW-1:0] fill_x(input int v);
        logic [N*IF*XW-1:0] r;
        for (int i = 0; i < N*IF; i++) r[i*XW +: XW] = XW'(v);
        return r;
    endfunction

    function automatic logic [IF*HF*WW-1:0] fill_w1(input int v);
        logic [IF*HF*WW-1:0] r;
        for (int i = 0; i < IF*HF; i++) r[i*WW +: WW] = WW'(v);
        return r;
    endfunction

    function automatic logic [HF*OF*WW-1:0] fill_w2(input int v);
        logic [HF*OF*WW-1:0] r;
        for (int i = 0; i < HF*OF; i++) r[i*WW +: WW] = WW'(v);
        return r;
    endfunction

    function automatic logic [OB-1:0] fill_out(input int v);
        logic [OB-1:0] r;
        for (int i = 0; i < N*OF; i++) r[i*OW +: OW] = OW'(v);
        return r;
    endfunction

    // Integer reference of the two-layer network.
    function automatic logic [OB-1:0] model(input logic [N*N-1:0] a,
                                            input logic [N*IF*XW-1:0] x,
                                            input logic [IF*HF*WW-1:0] wa,
                                            input logic [HF*OF*WW-1:0] wb,
                                            input logic relu);
        int ax[N][IF];
        int hid[N][HF];
        int ah[N][HF];
        int acc;
        logic signed [XW-1:0] xs;
        logic signed [WW-1:0] ws;
        logic [OB-1:0] r;
        for (int i = 0; i < N; i++)
            for (int f = 0; f < IF; f++) begin
                ax[i][f] = 0;
                for (int j = 0; j < N; j++)
                    if (a[i*N+j]) begin
                        xs = x[(j*IF+f)*XW +: XW];
                        ax[i][f] += int'(xs);
                    end
            end
        for (int i = 0; i < N; i++)
            for (int h = 0; h < HF; h++) begin
                acc = 0;
                for (int f = 0; f < IF; f++) begin
                    ws = wa[(h*IF+f)*WW +: WW];
                    acc += ax[i][f] * int'(ws);
                end
                hid[i][h] = (acc < 0) ? 0 : acc;
            end
        for (int i = 0; i < N; i++)
            for (int h = 0; h < HF; h++) begin
                ah[i][h] = 0;
                for (int j = 0; j < N; j++)
                    if (a[i*N+j]) ah[i][h] += hid[j][h];
            end
        for (int i = 0; i < N; i++)
            for (int o = 0; o < OF; o++) begin
                acc = 0;
                for (int h = 0; h < HF; h++) begin
                    ws = wb[(o*HF+h)*WW +: WW];
                    acc += ah[i][h] * int'(ws);
                end
                if (relu && acc < 0) acc = 0;
                r[(i*OF+o)*OW +: OW] = acc[OW-1:0];
            end
        return r;
    endfunction

    // Waits for in_ready, performs one handshake and returns at the negedge
    // after the capturing edge (the first L1 cycle), then scrambles inputs.
    task automatic drive_start(input string name,
                               input logic [N*N-1:0] a,
                               input logic [N*IF*XW-1:0] x,
                               input logic [IF*HF*WW-1:0] wa,
                               input logic [HF*OF*WW-1:0] wb,
                               input logic relu);
        int t = 0;
        @(negedge clk);
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            $display("FAIL %s start: in_ready=%b required=1", name, in_ready);
        end else begin
            n_pass++;
        end
        adj      = a;
        x_in     = x;
        w1       = wa;
        w2       = wb;
        out_relu = relu;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        adj      = N*N'($urandom);
        x_in     = fill_x(int'($urandom_range(0, 31)));
        w1       = fill_w1(int'($urandom_range(0, 31)));
        w2       = fill_w2(int'($urandom_range(0, 31)));
        out_relu = ~relu;
    endtask

    // Called at the first L1 negedge; counts negedges until out_valid.
    task automatic wait_result(input string name, input bit chk_lat);
        int cyc = 1;
        logic [OB-1:0] e;
        while (!out_valid && cyc < 60) begin
            @(negedge clk);
            cyc++;
        end
        if (chk_lat) begin
            n_checks++;
            if (cyc !== 8) $display("FAIL %s latency: got %0d cycles required 8", name, cyc);
            else n_pass++;
        end
        n_checks++;
        if (exp_q.size() == 0) begin
            $display("FAIL %s data: no expected entry queued", name);
        end else begin
            e = exp_q.pop_front();
            if (out_valid !== 1'b1)
                $display("FAIL %s data: out_valid=%b required=1 (timeout)", name, out_valid);
            else if (out_data !== e)
                $display("FAIL %s data: got %h required %h", name, out_data, e);
            else
                n_pass++;
        end
    endtask

    task automatic consume(input string name);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL %s out_valid after accept: got %b required 0", name, out_valid);
        else n_pass++;
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL %s in_ready after accept: got %b required 1", name, in_ready);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        adj       = '0;
        x_in      = '0;
        w1        = '0;
        w2        = '0;
        out_relu  = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL reset in_ready: got %b required 1", in_ready);
        else n_pass++;
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL reset out_valid: got %b required 0", out_valid);
        else n_pass++;
        n_checks++;
        if (out_data !== '0) $display("FAIL reset out_data: got %h required 0", out_data);
        else n_pass++;
        n_checks++;
        if (dbg_state !== 3'd0) $display("FAIL reset state: got %0d required 0", dbg_state);
        else n_pass++;
    endtask

    task automatic test_full_ones();
        exp_q.push_back(fill_out(256));
        drive_start("full_ones", '1, fill_x(1), fill_w1(1), fill_w2(1), 1'b0);
        wait_result("full_ones", 1'b1);
        consume("full_ones");
    endtask

    task automatic test_diamond();
        logic [N*N-1:0] a;
        a = {4'b1110, 4'b1101, 4'b1011, 4'b0111};
        exp_q.push_back(fill_out(144));
        drive_start("diamond", a, fill_x(1), fill_w1(1), fill_w2(1), 1'b0);
        wait_result("diamond", 1'b1);
        consume("diamond");
    endtask

    task automatic test_hidden_relu_and_zero_row();
        logic [OB-1:0] e;
        exp_q.push_back(fill_out(0));
        drive_start("hidden_relu", '1, fill_x(1), fill_w1(-1), fill_w2(1), 1'b0);
        wait_result("hidden_relu", 1'b0);
        consume("hidden_relu");
        e = fill_out(192);
        e[2*OF*OW +: OF*OW] = '0;
        exp_q.push_back(e);
        drive_start("zero_row", {4'hF, 4'h0, 4'hF, 4'hF}, fill_x(1), fill_w1(1), fill_w2(1), 1'b0);
        wait_result("zero_row", 1'b0);
        n_checks++;
        if (out_data[2*OF*OW +: OF*OW] !== '0)
            $display("FAIL zero_row node2: got %h required 0", out_data[2*OF*OW +: OF*OW]);
        else n_pass++;
        consume("zero_row");
    endtask

    task automatic test_negative_extreme();
        exp_q.push_back(fill_out(-1048576));
        drive_start("neg_extreme", '1, fill_x(-16), fill_w1(-16), fill_w2(-16), 1'b0);
        wait_result("neg_extreme", 1'b0);
        consume("neg_extreme");
        exp_q.push_back(fill_out(0));
        drive_start("neg_relu", '1, fill_x(-16), fill_w1(-16), fill_w2(-16), 1'b1);
        wait_result("neg_relu", 1'b0);
        consume("neg_relu");
    endtask

    task automatic test_backpressure();
        logic [OB-1:0] held;
        held = fill_out(256);
        exp_q.push_back(held);
        drive_start("backpressure", '1, fill_x(1), fill_w1(1), fill_w2(1), 1'b0);
        wait_result("backpressure", 1'b0);
        for (int c = 0; c < 5; c++) begin
            in_valid = c[0] ? 1'b0 : 1'b1;
            x_in     = fill_x(-7);
            @(negedge clk);
            n_checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0)
                $display("FAIL backpressure hold %0d: out_valid=%b in_ready=%b required 1/0", c, out_valid, in_ready);
            else n_pass++;
            n_checks++;
            if (out_data !== held) $display("FAIL backpressure data %0d: got %h required %h", c, out_data, held);
            else n_pass++;
        end
        in_valid = 1'b0;
        consume("backpressure");
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL backpressure ignored pulse: in_ready=%b required 1", in_ready);
        else n_pass++;
    endtask

    task automatic test_reset_mid_l2();
        drive_start("reset_mid", '1, fill_x(1), fill_w1(1), fill_w2(1), 1'b0);
        repeat (6) @(negedge clk);
        n_checks++;
        if (dbg_state !== 3'd3) $display("FAIL reset_mid in L2: state=%0d required 3", dbg_state);
        else n_pass++;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0)
            $display("FAIL reset_mid flags: in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
        else n_pass++;
        n_checks++;
        if (out_data !== '0) $display("FAIL reset_mid out_data: got %h required 0", out_data);
        else n_pass++;
        exp_q.push_back(fill_out(144));
        drive_start("after_reset", {4'b1110, 4'b1101, 4'b1011, 4'b0111},
                    fill_x(1), fill_w1(1), fill_w2(1), 1'b0);
        wait_result("after_reset", 1'b1);
        consume("after_reset");
    endtask

    task automatic test_back_to_back();
        logic [N*N-1:0]      a;
        logic [N*IF*XW-1:0]  x;
        logic [IF*HF*WW-1:0] wa;
        logic [HF*OF*WW-1:0] wb;
        logic                r;
        for (int it = 0; it < 6; it++) begin
            a = N*N'($urandom);
            for (int i = 0; i < N*IF; i++) x[i*XW +: XW] = XW'($urandom_range(0, 31));
            for (int i = 0; i < IF*HF; i++) wa[i*WW +: WW] = WW'($urandom_range(0, 31));
            for (int i = 0; i < HF*OF; i++) wb[i*WW +: WW] = WW'($urandom_range(0, 31));
            r = 1'($urandom_range(0, 1));
            exp_q.push_back(model(a, x, wa, wb, r));
            drive_start("back_to_back", a, x, wa, wb, r);
            wait_result("back_to_back", 1'b1);
            consume("back_to_back");
        end
    endtask

    initial begin
        test_reset();
        test_full_ones();
        test_diamond();
        test_hidden_relu_and_zero_row();
        test_negative_extreme();
        test_backpressure();
        test_reset_mid_l2();
        test_back_to_back();
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL scoreboard drain: %0d entries left required 0", exp_q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
